// File: rtl/ioctl_uploader_if.sv
// HPS ioctl upload bus plus the SDRAM read port used to serve it.
// slave: the uploader block; master: the HPS/memory side driving it.
interface ioctl_uploader_if #(
  parameter int unsigned AW = 25
) ();
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] rom_size;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          busy;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, rom_size, mem_dout,
    output ioctl_din, ioctl_wait, mem_addr, mem_rd, busy
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, rom_size, mem_dout,
    input  ioctl_din, ioctl_wait, mem_addr, mem_rd, busy
  );
endinterface

// File: rtl/ioctl_uploader.sv
// Serves HPS ioctl upload reads from SDRAM with a one-byte sequential
// prefetch buffer, a one-entry pending request slot and FILL beyond rom_size.
module ioctl_uploader #(
  parameter int unsigned AW     = 25,
  parameter int unsigned RD_LAT = 4,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input logic             clk_sys,
  input logic             reset,
  ioctl_uploader_if.slave bus
);

  typedef enum logic [2:0] { IDLE, FETCH, WAIT, PREFETCH, PWAIT } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    guard;
  logic [AW-1:0] last_addr;
  logic [7:0]    buf_data;
  logic [AW-1:0] buf_addr;
  logic          buf_valid;
  logic          pend;
  logic [AW-1:0] pend_addr;
  logic [7:0]    din_q;
  logic          wait_q;
  logic [AW-1:0] maddr_q;
  logic          mrd_q;

  logic          req_new;
  logic          req;
  logic [AW-1:0] req_addr;
  logic          req_hit;
  logic          req_fill;
  logic [AW-1:0] next_addr;

  // a fresh strobe is only accepted with no request already outstanding
  assign req_new   = bus.ioctl_upload && bus.ioctl_rd && !wait_q && !pend;
  assign req       = pend || req_new;
  assign req_addr  = pend ? pend_addr : bus.ioctl_addr;
  assign req_hit   = buf_valid && (buf_addr == req_addr);
  assign req_fill  = (req_addr >= bus.rom_size);
  assign next_addr = last_addr + AW'(1);

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_rd     = mrd_q;
  assign bus.busy       = (state != IDLE);

  // request sequencing, SDRAM read issue, prefetch buffer and pending slot
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      guard     <= '0;
      last_addr <= '0;
      buf_data  <= '0;
      buf_addr  <= '0;
      buf_valid <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      din_q     <= 8'h00;
      wait_q    <= 1'b0;
      maddr_q   <= '0;
      mrd_q     <= 1'b0;
    end else begin
      mrd_q <= 1'b0;
      // guard keeps a new mem_rd out of the previous read's latency window,
      // which matters only when a read was cut short by an abort
      if (guard != '0) guard <= guard - 4'd1;

      if (!bus.ioctl_upload) begin
        state     <= IDLE;
        buf_valid <= 1'b0;
        pend      <= 1'b0;
        wait_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (req) begin
              if (req_hit) begin
                din_q     <= buf_data;
                wait_q    <= 1'b0;
                pend      <= 1'b0;
                last_addr <= req_addr;
                state     <= PREFETCH;
              end else if (req_fill) begin
                din_q  <= FILL;
                wait_q <= 1'b0;
                pend   <= 1'b0;
              end else if (guard == '0) begin
                mrd_q     <= 1'b1;
                maddr_q   <= req_addr;
                last_addr <= req_addr;
                guard     <= 4'(RD_LAT);
                wait_q    <= 1'b1;
                pend      <= 1'b0;
                state     <= FETCH;
              end else begin
                pend      <= 1'b1;
                pend_addr <= req_addr;
                wait_q    <= 1'b1;
              end
            end
          end
          FETCH: begin
            cnt   <= 4'(RD_LAT - 1);
            state <= WAIT;
          end
          WAIT: begin
            if (cnt == '0) begin
              din_q  <= bus.mem_dout;
              wait_q <= 1'b0;
              state  <= PREFETCH;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          PREFETCH: begin
            buf_valid <= 1'b0;
            if (next_addr >= bus.rom_size) begin
              state <= IDLE;
            end else if (guard == '0) begin
              mrd_q   <= 1'b1;
              maddr_q <= next_addr;
              guard   <= 4'(RD_LAT);
              cnt     <= 4'(RD_LAT);
              state   <= PWAIT;
            end
          end
          PWAIT: begin
            if (cnt == '0) begin
              buf_data  <= bus.mem_dout;
              buf_addr  <= maddr_q;
              buf_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: state <= IDLE;
        endcase

        // a read landing mid-prefetch is parked and replayed from IDLE
        if ((state == PREFETCH || state == PWAIT) && req_new) begin
          pend      <= 1'b1;
          pend_addr <= bus.ioctl_addr;
          wait_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ioctl_uploader.sv
// Self-checking bench for ioctl_uploader: directed scenarios followed by
// randomized upload sessions against a request-level reference model.
module tb_ioctl_uploader;
  localparam int unsigned AW     = 8;
  localparam int unsigned RD_LAT = 4;
  localparam logic [7:0]  FILL   = 8'hFF;

  typedef struct {
    bit          done;
    int          n_wait;
    bit          gap;
    int          drop_idx;
    logic [7:0]  din_drop;
    int          n_rd;
    logic [15:0] rd_sig;
    int          first_rd;
  } obs_t;

  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ioctl_uploader_if #(.AW(AW)) bus ();

  ioctl_uploader #(.AW(AW), .RD_LAT(RD_LAT), .FILL(FILL)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: data valid exactly RD_LAT cycles after mem_rd, junk otherwise
  logic [7:0]    mem [256];
  logic [7:0]    cyc = 8'd0;
  logic [RD_LAT:1] sh_v = '0;
  logic [AW-1:0] sh_a [1:RD_LAT];

  always @(posedge clk_sys) begin
    cyc     <= cyc + 8'd1;
    sh_v[1] <= bus.mem_rd;
    sh_a[1] <= bus.mem_addr;
    for (int k = 2; k <= int'(RD_LAT); k++) begin
      sh_v[k] <= sh_v[k-1];
      sh_a[k] <= sh_a[k-1];
    end
  end

  assign bus.mem_dout = sh_v[RD_LAT] ? mem[sh_a[RD_LAT]] : (8'h3C ^ cyc);

  // spacing between SDRAM reads
  int rd_gap  = 0;
  int rd_viol = 0;
  bit rd_seen = 1'b0;
  always @(posedge clk_sys) begin
    if (bus.mem_rd === 1'b1) begin
      if (rd_seen && rd_gap < int'(RD_LAT) + 1) rd_viol <= rd_viol + 1;
      rd_seen <= 1'b1;
      rd_gap  <= 1;
    end else begin
      rd_gap <= rd_gap + 1;
    end
  end

  // reference model: what the prefetch buffer holds and the last byte served
  bit          m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]  exp_din = 8'h00;
  int          rom = 16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample outputs on falling edges until idle or ncyc cycles elapse
  task automatic watch(input int ncyc, output obs_t o);
    bit dropped;
    dropped = 1'b0;
    o.done = 1'b0; o.n_wait = 0; o.gap = 1'b0; o.drop_idx = -1; o.din_drop = '0;
    o.n_rd = 0; o.rd_sig = '0; o.first_rd = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      if (bus.mem_rd === 1'b1) begin
        if (o.first_rd < 0) o.first_rd = i;
        o.n_rd++;
        o.rd_sig = {o.rd_sig[7:0], 8'(bus.mem_addr)};
      end
      if (bus.ioctl_wait === 1'b1) begin
        o.n_wait++;
        if (dropped) o.gap = 1'b1;
      end else if (!dropped) begin
        dropped    = 1'b1;
        o.drop_idx = i;
        o.din_drop = bus.ioctl_din;
      end
      if (bus.ioctl_wait === 1'b0 && bus.busy === 1'b0) begin
        o.done = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_req(input logic [AW-1:0] a);
    obs_t o;
    bit fill, hit, miss, pf;
    logic [7:0]  exp_data;
    logic [15:0] exp_sig;
    int exp_wait;
    fill     = (int'(a) >= rom);
    hit      = !fill && m_valid && (m_addr == a);
    miss     = !fill && !hit;
    pf       = !fill && (int'(a) + 1 < rom);
    exp_data = fill ? FILL : mem[a];
    exp_sig  = '0;
    if (miss) exp_sig = {exp_sig[7:0], 8'(a)};
    if (pf)   exp_sig = {exp_sig[7:0], 8'(a + AW'(1))};
    exp_wait = miss ? int'(RD_LAT) + 1 : 0;
    @(negedge clk_sys);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    watch(80, o);
    chk("req_done", 32'(o.done), 32'd1);
    chk("wait_cycles", o.n_wait, exp_wait);
    chk("data_ready_cycle", o.drop_idx, exp_wait);
    chk("din", 32'(o.din_drop), 32'(exp_data));
    chk("mem_rd_count", o.n_rd, int'(miss) + int'(pf));
    chk("mem_rd_addrs", 32'(o.rd_sig), 32'(exp_sig));
    if (miss) chk("miss_rd_cycle", o.first_rd, 0);
    exp_din = exp_data;
    if (!fill) begin
      m_valid = pf;
      m_addr  = a + AW'(1);
    end
  endtask

  initial begin
    obs_t o;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h5A;
    mem[4] = 8'hC3;

    reset = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.rom_size     = AW'(16);
    repeat (2) @(negedge clk_sys);
    chk("rst_din", 32'(bus.ioctl_din), 32'h00);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b1;
    rom = 16;

    do_req(AW'(3));
    chk("miss_data_5a", 32'(bus.ioctl_din), 32'h5A);

    // hit on 4, then request 5 while the prefetch for 5 is in flight
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(4);
    watch(2, o);
    chk("hit_din", 32'(o.din_drop), 32'hC3);
    chk("hit_drop_idx", o.drop_idx, 0);
    chk("hit_no_wait", o.n_wait, 0);
    chk("hit_prefetch_rd", 32'(o.rd_sig), 32'h0005);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(5);
    watch(80, o);
    chk("pend_done", 32'(o.done), 32'd1);
    chk("pend_wait_contig", 32'(o.gap), 32'd0);
    chk("pend_wait_from_strobe", 32'(o.drop_idx == o.n_wait && o.n_wait >= 1), 32'd1);
    chk("pend_wait_bound", 32'(o.n_wait <= int'(RD_LAT) + 1), 32'd1);
    chk("pend_din", 32'(o.din_drop), 32'(mem[5]));
    chk("pend_rd_count", o.n_rd, 1);
    chk("pend_rd_addr", 32'(o.rd_sig), 32'h0006);
    m_valid = 1'b1; m_addr = AW'(6); exp_din = mem[5];

    do_req(AW'(16));
    do_req(AW'(15));

    // second strobe during a miss is ignored
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(10);
    watch(2, o);
    chk("viol_wait_early", o.n_wait, 2);
    chk("viol_first_rd", 32'(o.rd_sig), 32'h000A);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(2);
    watch(80, o);
    chk("viol_wait_rest", o.n_wait, int'(RD_LAT) - 1);
    chk("viol_din", 32'(o.din_drop), 32'(mem[10]));
    chk("viol_rd_addr", 32'(o.rd_sig), 32'h000B);
    chk("viol_rd_count", o.n_rd, 1);
    m_valid = 1'b1; m_addr = AW'(11); exp_din = mem[10];

    // upload dropped in WAIT
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(8);
    watch(3, o);
    chk("abort_in_wait", o.n_wait, 3);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_din", 32'(bus.ioctl_din), 32'(exp_din));
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(1);
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    chk("no_upload_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("no_upload_wait", 32'(bus.ioctl_wait), 32'd0);
    repeat (RD_LAT + 2) @(negedge clk_sys);
    chk("abort_late_din", 32'(bus.ioctl_din), 32'(exp_din));
    bus.ioctl_upload = 1'b1;
    m_valid = 1'b0;

    // reset in the middle of a fetch
    do_req(AW'(2));
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = AW'(7);
    watch(1, o);
    chk("pre_reset_fetch", o.first_rd, 0);
    reset = 1'b0;
    #1;
    chk("arst_din", 32'(bus.ioctl_din), 32'h00);
    chk("arst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk_sys);
    reset = 1'b1;
    m_valid = 1'b0; exp_din = 8'h00;
    repeat (8) @(negedge clk_sys);
    do_req(AW'(3));

    // randomized sessions, the first with an empty ROM
    for (int s = 0; s < 4; s++) begin
      @(negedge clk_sys);
      bus.ioctl_upload = 1'b0;
      @(negedge clk_sys);
      rom = (s == 0) ? 0 : int'($urandom_range(2, 40));
      bus.rom_size = AW'(rom);
      bus.ioctl_upload = 1'b1;
      m_valid = 1'b0;
      for (int n = 0; n < 12; n++) begin
        if (m_valid && $urandom_range(0, 2) == 0) a = m_addr;
        else a = AW'($urandom_range(0, rom + 3));
        repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        do_req(a);
      end
    end

    chk("mem_rd_spacing", rd_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
